// File: rtl/key_click_pkg.sv
// Shared types and default 50 MHz timing for the key click classifier.
// State encoding, timer terminal selection and a small max helper.
package key_click_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HELD
  } state_t;

  typedef enum logic [1:0] {
    SEL_LONG,
    SEL_GAP,
    SEL_REPEAT
  } term_sel_t;

  // Defaults correspond to 1 s hold, 300 ms gap and 200 ms repeat at 50 MHz.
  localparam int DEF_LONG_CYC    = 50_000_000;
  localparam int DEF_DBL_GAP_CYC = 15_000_000;
  localparam int DEF_REPEAT_CYC  = 10_000_000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Clearable up-counter shared by all classifier states; o_match flags the
// cycle in which the count equals the selected terminal value minus one.
module key_hold_timer
  import key_click_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int LONG_CYC    = DEF_LONG_CYC,
  parameter int DBL_GAP_CYC = DEF_DBL_GAP_CYC,
  parameter int REPEAT_CYC  = DEF_REPEAT_CYC
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_clear,
  input  term_sel_t i_sel,
  output logic      o_match
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_term;

  // The repeat terminal may be truncated when repeat is compiled out; the
  // classifier never consults the match in that configuration.
  always_comb begin
    w_term = CNT_W'(LONG_CYC - 1);
    case (i_sel)
      SEL_LONG:   w_term = CNT_W'(LONG_CYC - 1);
      SEL_GAP:    w_term = CNT_W'(DBL_GAP_CYC - 1);
      SEL_REPEAT: w_term = CNT_W'(REPEAT_CYC - 1);
      default:    w_term = CNT_W'(LONG_CYC - 1);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_match = (r_cnt == w_term);

endmodule

// File: rtl/key_click_classifier.sv
// Classifies debounced key gestures into single click, double click and long
// press pulses; auto-repeat while long-held is enabled by KEY_CLICK_REPEAT_EN.
module key_click_classifier
  import key_click_pkg::*;
#(
  parameter int LONG_CYC    = DEF_LONG_CYC,
  parameter int DBL_GAP_CYC = DEF_DBL_GAP_CYC,
  parameter int REPEAT_CYC  = DEF_REPEAT_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  input  logic key_value,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

`ifdef KEY_CLICK_REPEAT_EN
  localparam int CNT_MAX = max2(max2(LONG_CYC, DBL_GAP_CYC), REPEAT_CYC);
`else
  localparam int CNT_MAX = max2(LONG_CYC, DBL_GAP_CYC);
`endif
  localparam int CNT_W = $clog2(CNT_MAX);

  state_t    r_state;
  logic      r_short;
  logic      r_double;
  logic      r_long;
  logic      w_press;
  logic      w_release;
  logic      w_match;
  logic      w_clear;
  term_sel_t w_sel;

  assign w_press   = key_flag && !key_value;
  assign w_release = key_flag &&  key_value;

  always_comb begin
    w_sel = SEL_LONG;
    case (r_state)
      WAIT2:     w_sel = SEL_GAP;
      LONG_HELD: w_sel = SEL_REPEAT;
      default:   w_sel = SEL_LONG;
    endcase
  end

  // Timer restarts on every state entry and on each repeat tick.
  always_comb begin
    w_clear = 1'b0;
    case (r_state)
      IDLE:      w_clear = w_press;
      PRESS1:    w_clear = w_release || w_match;
      WAIT2:     w_clear = w_press || w_match;
      PRESS2:    w_clear = w_release;
`ifdef KEY_CLICK_REPEAT_EN
      LONG_HELD: w_clear = w_release || w_match;
`else
      LONG_HELD: w_clear = w_release;
`endif
      default:   w_clear = 1'b1;
    endcase
  end

  key_hold_timer #(
    .CNT_W      (CNT_W),
    .LONG_CYC   (LONG_CYC),
    .DBL_GAP_CYC(DBL_GAP_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_timer (
    .i_clk  (sys_clk),
    .i_rst_n(sys_rst_n),
    .i_clear(w_clear),
    .i_sel  (w_sel),
    .o_match(w_match)
  );

`ifdef KEY_CLICK_REPEAT_EN
  logic r_repeat;
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

  // Key events take priority over timer expiry in every state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
`ifdef KEY_CLICK_REPEAT_EN
      r_repeat <= 1'b0;
`endif
    end else begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
`ifdef KEY_CLICK_REPEAT_EN
      r_repeat <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_press) r_state <= PRESS1;
        end
        PRESS1: begin
          if (w_release) begin
            r_state <= WAIT2;
          end else if (w_match) begin
            r_state <= LONG_HELD;
            r_long  <= 1'b1;
          end
        end
        WAIT2: begin
          if (w_press) begin
            r_state  <= PRESS2;
            r_double <= 1'b1;
          end else if (w_match) begin
            r_state <= IDLE;
            r_short <= 1'b1;
          end
        end
        PRESS2: begin
          if (w_release) r_state <= IDLE;
        end
        LONG_HELD: begin
          if (w_release) begin
            r_state <= IDLE;
          end
`ifdef KEY_CLICK_REPEAT_EN
          else if (w_match) begin
            r_repeat <= 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign short_pulse  = r_short;
  assign double_pulse = r_double;
  assign long_pulse   = r_long;

endmodule

// File: tb/tb_key_click_classifier.sv
// Directed bench for key_click_classifier with LONG=20, GAP=8, REPEAT=5.
// Repeat expectations follow whether KEY_CLICK_REPEAT_EN is defined.
module tb_key_click_classifier;

`ifdef KEY_CLICK_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic sys_clk;
  logic sys_rst_n;
  logic key_flag;
  logic key_value;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;

  int nCompared;
  int nMismatched;

  int nShort, firstShort, lastShort;
  int nDouble, firstDouble;
  int nLong, firstLong;
  int nRep, firstRep;
  int nMulti;

  key_click_classifier #(
    .LONG_CYC   (20),
    .DBL_GAP_CYC(8),
    .REPEAT_CYC (5)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic applyReset();
    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    key_value = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  // Drives one gesture; cycle c's inputs are sampled at the edge ending c,
  // so outputs observed after that edge belong to cycle c+1.
  task automatic runGesture(input int p1, input int r1, input int p2, input int r2,
                            input int rstAt, input int total);
    nShort = 0; firstShort = -1; lastShort = -1;
    nDouble = 0; firstDouble = -1;
    nLong = 0; firstLong = -1;
    nRep = 0; firstRep = -1;
    nMulti = 0;
    for (int c = 0; c < total; c++) begin
      key_flag = 1'b0;
      if (c == p1 || c == p2) begin
        key_flag  = 1'b1;
        key_value = 1'b0;
      end else if (c == r1 || c == r2) begin
        key_flag  = 1'b1;
        key_value = 1'b1;
      end
      sys_rst_n = !(rstAt >= 0 && (c == rstAt || c == rstAt + 1));
      @(posedge sys_clk);
      #1;
      if (short_pulse === 1'b1) begin
        nShort++;
        if (firstShort < 0) firstShort = c + 1;
        lastShort = c + 1;
      end
      if (double_pulse === 1'b1) begin
        nDouble++;
        if (firstDouble < 0) firstDouble = c + 1;
      end
      if (long_pulse === 1'b1) begin
        nLong++;
        if (firstLong < 0) firstLong = c + 1;
      end
      if (repeat_pulse === 1'b1) begin
        nRep++;
        if (firstRep < 0) firstRep = c + 1;
      end
      if (int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1)
        nMulti++;
    end
    key_flag  = 1'b0;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    key_value = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    nCompared++;
    if ({short_pulse, double_pulse, long_pulse, repeat_pulse} !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL reset.outputs got %b want 0000",
               {short_pulse, double_pulse, long_pulse, repeat_pulse});
    end
    sys_rst_n = 1'b1;
    runGesture(-1, -1, -1, -1, -1, 30);
    nCompared++;
    if (nShort + nDouble + nLong + nRep !== 0) begin
      nMismatched++;
      $display("[TB] FAIL reset.idle_pulses got %0d want 0", nShort + nDouble + nLong + nRep);
    end
  endtask

  task automatic test_single_click();
    applyReset();
    runGesture(10, 15, -1, -1, -1, 40);
    nCompared++;
    if (nShort !== 1) begin
      nMismatched++;
      $display("[TB] FAIL single.count got %0d want 1", nShort);
    end
    nCompared++;
    if (firstShort !== 24) begin
      nMismatched++;
      $display("[TB] FAIL single.cycle got %0d want 24", firstShort);
    end
    nCompared++;
    if (nDouble + nLong + nRep !== 0) begin
      nMismatched++;
      $display("[TB] FAIL single.others got %0d want 0", nDouble + nLong + nRep);
    end
  endtask

  task automatic test_double_click();
    applyReset();
    runGesture(10, 14, 18, 22, -1, 45);
    nCompared++;
    if (nDouble !== 1) begin
      nMismatched++;
      $display("[TB] FAIL double.count got %0d want 1", nDouble);
    end
    nCompared++;
    if (firstDouble !== 19) begin
      nMismatched++;
      $display("[TB] FAIL double.cycle got %0d want 19", firstDouble);
    end
    nCompared++;
    if (nShort + nLong + nRep !== 0) begin
      nMismatched++;
      $display("[TB] FAIL double.others got %0d want 0", nShort + nLong + nRep);
    end
  endtask

  task automatic test_long_press();
    applyReset();
    runGesture(10, 40, -1, -1, -1, 60);
    nCompared++;
    if (nLong !== 1) begin
      nMismatched++;
      $display("[TB] FAIL long.count got %0d want 1", nLong);
    end
    nCompared++;
    if (firstLong !== 31) begin
      nMismatched++;
      $display("[TB] FAIL long.cycle got %0d want 31", firstLong);
    end
    nCompared++;
    if (nRep !== (REP_EN ? 1 : 0)) begin
      nMismatched++;
      $display("[TB] FAIL long.repeat_count got %0d want %0d", nRep, REP_EN ? 1 : 0);
    end
    nCompared++;
    if (firstRep !== (REP_EN ? 36 : -1)) begin
      nMismatched++;
      $display("[TB] FAIL long.repeat_cycle got %0d want %0d", firstRep, REP_EN ? 36 : -1);
    end
    nCompared++;
    if (nShort + nDouble + nMulti !== 0) begin
      nMismatched++;
      $display("[TB] FAIL long.others got %0d want 0", nShort + nDouble + nMulti);
    end
  endtask

  task automatic test_release_at_threshold();
    applyReset();
    runGesture(10, 30, -1, -1, -1, 50);
    nCompared++;
    if (nLong !== 0) begin
      nMismatched++;
      $display("[TB] FAIL thresh.long got %0d want 0", nLong);
    end
    nCompared++;
    if (nShort !== 1 || firstShort !== 39) begin
      nMismatched++;
      $display("[TB] FAIL thresh.short got count %0d at %0d want 1 at 39", nShort, firstShort);
    end
  endtask

  task automatic test_press_at_gap_expiry();
    applyReset();
    runGesture(10, 15, 23, 26, -1, 45);
    nCompared++;
    if (nDouble !== 1 || firstDouble !== 24) begin
      nMismatched++;
      $display("[TB] FAIL gapedge.double got count %0d at %0d want 1 at 24", nDouble, firstDouble);
    end
    nCompared++;
    if (nShort !== 0) begin
      nMismatched++;
      $display("[TB] FAIL gapedge.short got %0d want 0", nShort);
    end
  endtask

  task automatic test_reset_mid_gesture();
    applyReset();
    runGesture(10, 15, -1, 22, 18, 60);
    nCompared++;
    if (nShort + nDouble + nLong + nRep !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rstwait.pulses got %0d want 0", nShort + nDouble + nLong + nRep);
    end
    applyReset();
    runGesture(10, 20, -1, -1, 13, 60);
    nCompared++;
    if (nShort + nDouble + nLong + nRep !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rsthold.pulses got %0d want 0", nShort + nDouble + nLong + nRep);
    end
  endtask

  task automatic test_hold_sixty();
    applyReset();
    runGesture(5, 65, -1, -1, -1, 80);
    nCompared++;
    if (nLong !== 1 || firstLong !== 26) begin
      nMismatched++;
      $display("[TB] FAIL hold60.long got count %0d at %0d want 1 at 26", nLong, firstLong);
    end
    nCompared++;
    if (nRep !== (REP_EN ? 7 : 0)) begin
      nMismatched++;
      $display("[TB] FAIL hold60.repeat_count got %0d want %0d", nRep, REP_EN ? 7 : 0);
    end
    nCompared++;
    if (firstRep !== (REP_EN ? 31 : -1)) begin
      nMismatched++;
      $display("[TB] FAIL hold60.repeat_cycle got %0d want %0d", firstRep, REP_EN ? 31 : -1);
    end
    nCompared++;
    if (nMulti !== 0) begin
      nMismatched++;
      $display("[TB] FAIL hold60.overlap got %0d want 0", nMulti);
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    runGesture(5, 8, 20, 22, -1, 45);
    nCompared++;
    if (nShort !== 2) begin
      nMismatched++;
      $display("[TB] FAIL b2b.count got %0d want 2", nShort);
    end
    nCompared++;
    if (firstShort !== 17 || lastShort !== 31) begin
      nMismatched++;
      $display("[TB] FAIL b2b.cycles got %0d,%0d want 17,31", firstShort, lastShort);
    end
    nCompared++;
    if (nDouble + nLong !== 0) begin
      nMismatched++;
      $display("[TB] FAIL b2b.others got %0d want 0", nDouble + nLong);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    sys_rst_n   = 1'b0;
    key_flag    = 1'b0;
    key_value   = 1'b1;
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_release_at_threshold();
    test_press_at_gap_expiry();
    test_reset_mid_gesture();
    test_hold_sixty();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/key_click_classifier.md
# key_click_classifier

Downstream consumer of the key debounce stage. Takes the debounced key event pulse and level and classifies each gesture as a single click, a double click or a long press, emitting a one-cycle pulse per classified event. Sits between the debouncer and application logic (LED toggling, mode selection), replacing direct use of the raw debounce flag.

## Interface

Parameters:
- LONG_CYC, 50_000_000: hold duration in cycles that qualifies a long press (1 s at 50 MHz); must be ≥ 2.
- DBL_GAP_CYC, 15_000_000: maximum released gap in cycles between first release and second press for a double click (300 ms); must be ≥ 2.
- REPEAT_CYC, 10_000_000: auto-repeat period in cycles while long-held; used only when KEY_CLICK_REPEAT_EN is defined.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  reset, synchronous and active-low.
- key_flag  in  1  one-cycle pulse from the debouncer on each debounced level change.
- key_value  in  1  debounced key level; 0 = pressed, 1 = released.
- short_pulse  out  1  one-cycle pulse: single click classified.
- double_pulse  out  1  one-cycle pulse: double click classified.
- long_pulse  out  1  one-cycle pulse: long press threshold reached.
- repeat_pulse  out  1  one-cycle pulse: auto-repeat tick while long-held.

## Operation

- Press event = key_flag && !key_value; release event = key_flag && key_value. key_flag with the direction not expected in the current state is ignored.
- Single timer cnt, width $clog2(max(LONG_CYC, DBL_GAP_CYC, REPEAT_CYC)), cleared to 0 on every state entry, increments each cycle otherwise.
- States and transitions:
  - IDLE: press → PRESS1.
  - PRESS1: release → WAIT2; else cnt == LONG_CYC-1 → LONG_HELD, assert long_pulse.
  - WAIT2: press → PRESS2, assert double_pulse; else cnt == DBL_GAP_CYC-1 → IDLE, assert short_pulse.
  - PRESS2: release → IDLE. No long-press classification in this state.
  - LONG_HELD: release → IDLE; with repeat enabled, cnt == REPEAT_CYC-1 → assert repeat_pulse, cnt cleared, stay.
- Simultaneous events: release beats long threshold in PRESS1 (gesture becomes a click candidate); press beats gap timeout in WAIT2 (double click).
- Outputs are registered, mutually exclusive; at most one asserted in any cycle.

## Timing

- Reset: state IDLE, cnt 0, all four outputs 0. Reset mid-gesture abandons it with no pulse; a key still held after reset release is ignored until its release and a new press.
- Press flag at cycle P, no release: long_pulse high at P+LONG_CYC+1.
- Release flag at cycle T, no further press: short_pulse high at T+DBL_GAP_CYC+1.
- Second press flag at cycle Q in WAIT2: double_pulse high at Q+1.
- Repeat: first repeat_pulse REPEAT_CYC cycles after long_pulse, then every REPEAT_CYC cycles until release.
- Every output pulse is exactly one cycle wide.

## Configuration

- KEY_CLICK_REPEAT_EN defined: LONG_HELD generates repeat_pulse as specified.
- Not defined: repeat_pulse tied to 0, REPEAT_CYC ignored and excluded from cnt width; LONG_HELD only waits for release.

## Structure

- Shared package/header key_click_pkg: state encoding constants (IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD) and default timing constants for 50 MHz.
- One natural sub-module: key_hold_timer: clearable up-counter with terminal-match output, instantiated once and driven by the FSM's clear and terminal-value select.

## Test plan

Bench parameters: LONG_CYC=20, DBL_GAP_CYC=8, REPEAT_CYC=5, KEY_CLICK_REPEAT_EN defined.
- Press at cycle 10, release at 15, idle → short_pulse only, single cycle at 24.
- Press 10, release 14, press 18, release 22 → double_pulse at 19 only; no short_pulse.
- Press at 10, hold to 40 → long_pulse at 31, repeat_pulse at 36; release at 40 → no further pulses.
- Release flag in same cycle cnt reaches 19 (PRESS1) → no long_pulse; short_pulse 9 cycles later. Second press in same cycle gap expires → double_pulse, no short_pulse.
- Assert sys_rst_n=0 for 2 cycles mid-WAIT2, then release key-up → all outputs 0, no short_pulse ever; spurious release flag in IDLE ignored.
- Rebuild without KEY_CLICK_REPEAT_EN, hold 60 cycles → long_pulse once, repeat_pulse constantly 0.
